// File: rtl/dma_test_pkg.sv
// dma_test_pkg: shared states, channel test-pattern tags and stall LFSR seed for the DMA loopback checkers
package dma_test_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} chk_state_t;
  localparam logic [31:0] TAG_CH0 = 32'h00bbccdd;
  localparam logic [31:0] TAG_CH1 = 32'h11bbccdd;
  localparam logic [31:0] TAG_CH2 = 32'h22bbccdd;
  localparam logic [31:0] TAG_CH3 = 32'h33bbccdd;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
endpackage

// File: rtl/stall_lfsr.sv
// stall_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11) producing a pseudo-random stall bit
module stall_lfsr
  import dma_test_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic stall
);
  logic [15:0] lfsr;
  always_ff @(posedge clk or posedge reset)
    if (reset) lfsr <= LFSR_SEED;
    else if (load) lfsr <= LFSR_SEED;
    else if (en) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign stall = lfsr[0];
endmodule

// File: rtl/dma_stream_checker.sv
// dma_stream_checker: checks a DMA read stream against {tag, seq}; DMA_CHECKER_RANDOM_STALL_EN adds random back-pressure
module dma_stream_checker
  import dma_test_pkg::*;
#(
  parameter int DWIDTH = 64,
  parameter int CWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       expect_tag,
  input  logic [CWIDTH-1:0] expect_count,
  input  logic [31:0]       seq_base,
  input  logic [DWIDTH-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CWIDTH-1:0] word_count,
  output logic [CWIDTH-1:0] err_count,
  output logic [CWIDTH-1:0] first_err_index,
  output logic [DWIDTH-1:0] first_err_data
);
  chk_state_t        state;
  logic [31:0]       tag_q, seq_q;
  logic [CWIDTH-1:0] len_q, s1_idx;
  logic [DWIDTH-1:0] s1_data, s1_exp;
  logic              s1_v, stall, arm, accept;
  assign arm = start & (state == IDLE | state == DONE);
`ifdef DMA_CHECKER_RANDOM_STALL_EN
  stall_lfsr u_lfsr (.clk(clk), .reset(reset), .load(arm), .en(state == RUN), .stall(stall));
`else
  assign stall = 1'b0;
`endif
  assign ready = (state == RUN) & ~stall;
  assign accept = valid & ready;
  assign busy = (state == RUN) | (state == DRAIN);
  assign done = state == DONE;
  assign pass = done & (err_count == '0);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      tag_q <= '0;
      seq_q <= '0;
      len_q <= '0;
      s1_v <= 1'b0;
      s1_idx <= '0;
      s1_data <= '0;
      s1_exp <= '0;
      word_count <= '0;
      err_count <= '0;
      first_err_index <= '0;
      first_err_data <= '0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_data <= data;
        s1_exp <= {tag_q, seq_q};
        s1_idx <= word_count;
        word_count <= word_count + 1'b1;
        seq_q <= seq_q + 1'b1;
      end
      if (s1_v && s1_data != s1_exp) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (err_count == '0) begin
          first_err_index <= s1_idx;
          first_err_data <= s1_data;
        end
      end
      case (state)
        IDLE, DONE:
          if (start) begin
            state <= (expect_count == '0) ? DRAIN : RUN;
            tag_q <= expect_tag;
            seq_q <= seq_base;
            len_q <= expect_count;
            word_count <= '0;
            err_count <= '0;
            first_err_index <= '0;
            first_err_data <= '0;
          end
        RUN: if (accept && word_count + 1'b1 == len_q) state <= DRAIN;
        // ready is low here, so stage 1 holds at most the final beat and retires it on this edge
        DRAIN: state <= DONE;
      endcase
    end
endmodule
